// File: rtl/malformed_test_result_capture.sv
// malformed_test_result_capture
// Captures the malformed-constraints test IP's registered result into a
// show-ahead FIFO and hands it to the harness over a valid/ready port.
// A running XOR checksum and a saturating drop counter are kept so the
// result path has real register-to-register timing across the IP boundary.
//
// Optional build macro: CAPTURE_PARITY_EN
//   When defined, each entry carries an even-parity bit written alongside
//   the data, and the ports out_par_err / par_err_seen are added.
module malformed_test_result_capture #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              clr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  level,
  output logic              full,
  output logic              overflow,
  output logic [7:0]        drop_cnt,
  output logic [DATA_W-1:0] checksum
`ifdef CAPTURE_PARITY_EN
  ,
  output logic              out_par_err,
  output logic              par_err_seen
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

`ifdef CAPTURE_PARITY_EN
  localparam int ENTRY_W = DATA_W + 1;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  // Storage array; contents are not reset, empty state is masked at the output.
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]  level_q,    level_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;

  logic               empty;
  logic               is_full;
  logic               rd;
  logic               wr;
  logic               drop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

`ifdef CAPTURE_PARITY_EN
  logic par_err_seen_q, par_err_seen_d;
  logic head_par_err;
`endif

  // Full/empty come from the occupancy count so pointer equality is never ambiguous.
  assign empty   = (level_q == '0);
  assign is_full = (level_q == CNT_W'(DEPTH));

  // A full FIFO still accepts a word when the head is leaving in the same cycle.
  assign rd   = !empty & out_ready;
  assign wr   = in_valid & (!is_full | rd);
  assign drop = in_valid & is_full & !rd;

  assign head_entry = mem_q[rd_ptr_q];

`ifdef CAPTURE_PARITY_EN
  // Even parity: stored bit makes the total count of ones even.
  assign wr_entry     = {^in_data, in_data};
  assign head_par_err = !empty & ((^head_entry[DATA_W-1:0]) != head_entry[DATA_W]);
`else
  assign wr_entry = in_data;
`endif

  // Show-ahead read port: head word is presented combinationally, zero when empty.
  always_comb begin
    out_data = '0;
    if (!empty) begin
      out_data = head_entry[DATA_W-1:0];
    end
  end

  assign out_valid = !empty;
  assign level     = level_q;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign checksum  = checksum_q;

`ifdef CAPTURE_PARITY_EN
  assign out_par_err  = head_par_err;
  assign par_err_seen = par_err_seen_q;
`endif

  // Next-state for pointers, occupancy, drop tracking and checksum; clr wins over everything.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    checksum_d = checksum_q;
`ifdef CAPTURE_PARITY_EN
    par_err_seen_d = par_err_seen_q;
`endif
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
      checksum_d = '0;
`ifdef CAPTURE_PARITY_EN
      par_err_seen_d = 1'b0;
`endif
    end else begin
      if (wr) begin
        // DEPTH is a power of two, so the pointer wraps by plain overflow.
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        checksum_d = checksum_q ^ in_data;
      end
      if (rd) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (wr && !rd) begin
        level_d = level_q + CNT_W'(1);
      end else if (rd && !wr) begin
        level_d = level_q - CNT_W'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
`ifdef CAPTURE_PARITY_EN
      if (rd && head_par_err) begin
        par_err_seen_d = 1'b1;
      end
`endif
    end
  end

  // Control and status registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      checksum_q <= '0;
`ifdef CAPTURE_PARITY_EN
      par_err_seen_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      checksum_q <= checksum_d;
`ifdef CAPTURE_PARITY_EN
      par_err_seen_q <= par_err_seen_d;
`endif
    end
  end

  // Entry write; a clr in the same cycle suppresses the store.
  always_ff @(posedge clk) begin
    if (wr && !clr) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_malformed_test_result_capture.sv
// Directed testbench for malformed_test_result_capture (DATA_W=8, DEPTH=8).
module tb_malformed_test_result_capture;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              clr;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  level;
  logic              full;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic [DATA_W-1:0] checksum;
`ifdef CAPTURE_PARITY_EN
  logic              out_par_err;
  logic              par_err_seen;
`endif

  int n_checks;
  int n_errors;

  malformed_test_result_capture #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .clr      (clr),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level),
    .full     (full),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .checksum (checksum)
`ifdef CAPTURE_PARITY_EN
    ,
    .out_par_err (out_par_err),
    .par_err_seen(par_err_seen)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] drain_exp [8];
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_level",    32'(level),     32'd0);
    check("rst_valid",    32'(out_valid), 32'd0);
    check("rst_full",     32'(full),      32'd0);
    check("rst_data",     32'(out_data),  32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    check("rst_drop",     32'(drop_cnt),  32'd0);
    check("rst_checksum", 32'(checksum),  32'd0);
    rst_n = 1'b1;
    step();
    $display("reset released");

    // Push 0x11, 0x22, 0x33 with out_ready low
    in_valid = 1'b1; in_data = 8'h11;
    step();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data",  32'(out_data),  32'h11);
    in_data = 8'h22;
    step();
    in_data = 8'h33;
    step();
    in_valid = 1'b0;
    step();
    check("push3_level",    32'(level),    32'd3);
    check("push3_data",     32'(out_data), 32'h11);
    check("push3_checksum", 32'(checksum), 32'h00);
    check("push3_full",     32'(full),     32'd0);
    $display("pushed 11 22 33: level=%0d head=%0h", level, out_data);

    // Drain
    out_ready = 1'b1;
    check("drain_0", 32'(out_data), 32'h11);
    step();
    check("drain_1", 32'(out_data), 32'h22);
    step();
    check("drain_2", 32'(out_data), 32'h33);
    step();
    check("drain_level", 32'(level),     32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data",  32'(out_data),  32'd0);
    out_ready = 1'b0;
    $display("drained 3 words");

    // Fill 8 one-hot words, then 3 drops
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(1 << i);
      step();
    end
    check("fill_full",     32'(full),     32'd1);
    check("fill_level",    32'(level),    32'd8);
    check("fill_overflow", 32'(overflow), 32'd0);
    in_data = 8'hAA; step();
    in_data = 8'hBB; step();
    in_data = 8'hCC; step();
    in_valid = 1'b0;
    check("ovf_full",     32'(full),     32'd1);
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_drop",     32'(drop_cnt), 32'd3);
    check("ovf_checksum", 32'(checksum), 32'hFF);
    check("ovf_level",    32'(level),    32'd8);
    check("ovf_head",     32'(out_data), 32'h01);
    $display("filled 8, dropped 3: drop_cnt=%0d checksum=%0h", drop_cnt, checksum);

    // Full with simultaneous read and write
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("rw_level",    32'(level),    32'd8);
    check("rw_drop",     32'(drop_cnt), 32'd3);
    check("rw_checksum", 32'(checksum), 32'h5A);
    $display("full read+write of A5: level=%0d", level);
    drain_exp[0] = 8'h02; drain_exp[1] = 8'h04; drain_exp[2] = 8'h08; drain_exp[3] = 8'h10;
    drain_exp[4] = 8'h20; drain_exp[5] = 8'h40; drain_exp[6] = 8'h80; drain_exp[7] = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tail_drain_%0d", i), 32'(out_data), 32'(drain_exp[i]));
      step();
    end
    out_ready = 1'b0;
    check("tail_level", 32'(level), 32'd0);
    $display("drained 8 words ending with A5");

    // clr together with a write
    in_valid = 1'b1; in_data = 8'h77;
    step();
    check("preclr_checksum", 32'(checksum), 32'h2D);
    clr = 1'b1; in_data = 8'hFF;
    step();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_level",    32'(level),     32'd0);
    check("clr_checksum", 32'(checksum),  32'd0);
    check("clr_overflow", 32'(overflow),  32'd0);
    check("clr_drop",     32'(drop_cnt),  32'd0);
    check("clr_valid",    32'(out_valid), 32'd0);
    step();
    check("clr_nostore", 32'(level), 32'd0);
    $display("clr with write of FF: level=%0d", level);

    // Drop counter saturation
    in_valid = 1'b1;
    for (int i = 0; i < 8 + 260; i++) begin
      in_data = 8'(i);
      step();
    end
    in_valid = 1'b0;
    check("sat_drop",  32'(drop_cnt), 32'd255);
    check("sat_level", 32'(level),    32'd8);
    $display("saturation: drop_cnt=%0d", drop_cnt);
    clr = 1'b1;
    step();
    clr = 1'b0;

    // Async reset mid-stream with 5 words queued
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h30 + i);
      step();
    end
    in_valid = 1'b0;
    check("mid_level", 32'(level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level",    32'(level),     32'd0);
    check("arst_valid",    32'(out_valid), 32'd0);
    check("arst_data",     32'(out_data),  32'd0);
    check("arst_checksum", 32'(checksum),  32'd0);
    check("arst_full",     32'(full),      32'd0);
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    check("post_data",     32'(out_data), 32'h5A);
    check("post_level",    32'(level),    32'd1);
    check("post_checksum", 32'(checksum), 32'h5A);
    $display("after async reset pushed 5A: head=%0h level=%0d", out_data, level);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
